// File: rtl/io_display_pkg.sv
// rtl/io_display_pkg.sv - shared types and constants for the IO display driver
package io_display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    localparam int BCD_DIGITS   = 10;
    localparam int SHIFT_CYCLES = 32;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Pre-shift correction: any nibble that would reach 10 or more after doubling gets +3.
    function automatic logic [4*BCD_DIGITS-1:0] dabble_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [4*BCD_DIGITS-1:0] res;
        res = bcd;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/io_display_bcd_to_seven_seg.sv
// rtl/io_display_bcd_to_seven_seg.sv - BCD digit to active-low {g,f,e,d,c,b,a} segments
module bcd_to_seven_seg
    import io_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/io_display_driver.sv
// rtl/io_display_driver.sv - snoops IO RAM stores and shows the display word in decimal
module io_display_driver
    import io_display_pkg::*;
#(
    parameter logic [9:0] DISPLAY_ADDR = 10'd0,
    parameter int         DIGITS       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           dataC,
    input  logic [9:0]            address,
    input  logic                  IO_RAMwrite,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  sign,
    output logic                  overflow,
    output logic                  busy
);

    state_t                    state;
    logic [31:0]               mag;
    logic [4*BCD_DIGITS-1:0]   bcd;
    logic [4*BCD_DIGITS-1:0]   bcd_adj;
    logic [4:0]                cnt;
    logic                      neg;
    logic                      pend_valid;
    logic [31:0]               pend_data;
    logic                      store;
    logic [31:0]               start_word;
    logic [7*DIGITS-1:0]       seg_raw;
    logic [7*DIGITS-1:0]       disp_next;
    logic                      ovf_next;
    logic                      seen;

    assign store      = IO_RAMwrite && (address == DISPLAY_ADDR);
    assign bcd_adj    = dabble_adjust(bcd);
    // A queued word always takes priority over a fresh store when a conversion starts.
    assign start_word = pend_valid ? pend_data : dataC;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seven_seg u_dec (
            .digit (bcd[4*g +: 4]),
            .seg   (seg_raw[7*g +: 7])
        );
    end

    always_comb begin
        ovf_next  = 1'b0;
        seen      = 1'b0;
        disp_next = '1;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (k >= DIGITS && bcd[4*k +: 4] != 4'd0) begin
                ovf_next = 1'b1;
            end
        end
        // Walk from the top digit down so leading zeros blank until the first nonzero digit.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd[4*k +: 4] != 4'd0 || k == 0) begin
                seen = 1'b1;
            end
            if (ovf_next) begin
                disp_next[7*k +: 7] = SEG_DASH;
            end else if (seen) begin
                disp_next[7*k +: 7] = seg_raw[7*k +: 7];
            end else begin
                disp_next[7*k +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            hex        <= {DIGITS{SEG_BLANK}};
            sign       <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (store && state != IDLE) begin
                pend_data  <= dataC;
                pend_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pend_valid || store) begin
                        neg        <= start_word[31];
                        mag        <= start_word[31] ? (~start_word + 32'd1) : start_word;
                        bcd        <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                        pend_valid <= pend_valid && store;
                        if (pend_valid && store) begin
                            pend_data <= dataC;
                        end
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    cnt        <= cnt + 5'd1;
                    if (cnt == 5'(SHIFT_CYCLES - 1)) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    hex      <= disp_next;
                    sign     <= neg;
                    overflow <= ovf_next;
                    busy     <= pend_valid || store;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
